// File: rtl/taximeter_fare_core.sv
`default_nettype none
// ============================================================================
// taximeter_fare_core : trip state machine turning wheel edges and a 1 Hz tick
// into mileage, waiting minutes and fare. Optional macro: NIGHT_RATE_EN.
// Revision: 1.0
// ============================================================================
module taximeter_fare_core #(
  parameter int PULSES_PER_KM = 10,
  parameter int BASE_KM       = 3,
  parameter int BASE_FARE     = 10,
  parameter int PER_KM        = 2,
  parameter int PER_WAIT_MIN  = 1,
  parameter int WAIT_TRIG_S   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        wheel_in,
  input  logic        tick_1hz,
`ifdef NIGHT_RATE_EN
  input  logic        night,
`endif
  output logic [7:0]  mil,
  output logic [6:0]  timee,
  output logic [10:0] cost,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  localparam logic [7:0]  c_PULSE_LAST = 8'(PULSES_PER_KM - 1);
  localparam logic [7:0]  c_BASE_KM    = 8'(BASE_KM);
  localparam logic [10:0] c_BASE_FARE  = 11'(BASE_FARE);
  localparam logic [10:0] c_PER_KM     = 11'(PER_KM);
  localparam logic [10:0] c_PER_WAIT   = 11'(PER_WAIT_MIN);
  localparam logic [7:0]  c_WAIT_TRIG  = 8'(WAIT_TRIG_S);
  localparam logic [7:0]  c_MIL_MAX    = 8'd99;
  localparam logic [6:0]  c_TIME_MAX   = 7'd59;
  localparam logic [5:0]  c_SEC_LAST   = 6'd59;
  localparam logic [10:0] c_COST_MAX   = 11'd999;

  logic        r_sync1, r_sync2, r_sync3;
  state_t      r_state,     w_state_nx;
  logic [7:0]  r_pulse_cnt, w_pulse_nx;
  logic [7:0]  r_idle_s,    w_idle_nx;
  logic [5:0]  r_sec_cnt,   w_sec_nx;
  logic [7:0]  r_mil,       w_mil_nx;
  logic [6:0]  r_timee,     w_timee_nx;
  logic [10:0] r_cost,      w_cost_nx;

  logic        w_wheel_p;
  logic        w_pulse_wrap;
  logic [7:0]  w_pulse_step;
  logic [7:0]  w_mil_step;
  logic [10:0] w_km_rate;
  logic [10:0] w_cost_km;
  logic [10:0] w_cost_min;

  function automatic logic [10:0] f_sat_add(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, c_COST_MAX}) ? c_COST_MAX : s[10:0];
  endfunction

  assign w_wheel_p    = r_sync2 & ~r_sync3;
  assign w_pulse_wrap = (r_pulse_cnt == c_PULSE_LAST);
  assign w_pulse_step = w_pulse_wrap ? 8'd0 : r_pulse_cnt + 8'd1;
  assign w_mil_step   = (r_mil == c_MIL_MAX) ? r_mil : r_mil + 8'd1;

`ifdef NIGHT_RATE_EN
  assign w_km_rate = night ? c_PER_KM + 11'd1 : c_PER_KM;
`else
  assign w_km_rate = c_PER_KM;
`endif

  // Charge uses the mileage before this km step is counted.
  assign w_cost_km  = (r_mil >= c_BASE_KM) ? f_sat_add(r_cost, w_km_rate) : r_cost;
  assign w_cost_min = f_sat_add(r_cost, c_PER_WAIT);

  always_comb begin
    w_state_nx = r_state;
    w_pulse_nx = r_pulse_cnt;
    w_idle_nx  = r_idle_s;
    w_sec_nx   = r_sec_cnt;
    w_mil_nx   = r_mil;
    w_timee_nx = r_timee;
    w_cost_nx  = r_cost;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (start && !stop) begin
          w_state_nx = S_RUN;
          w_pulse_nx = 8'd0;
          w_idle_nx  = 8'd0;
          w_sec_nx   = 6'd0;
          w_mil_nx   = 8'd0;
          w_timee_nx = 7'd0;
          w_cost_nx  = c_BASE_FARE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nx = S_HOLD;
        end else if (w_wheel_p) begin
          // An edge restarts the idle window even if a tick lands in the same cycle.
          w_idle_nx  = 8'd0;
          w_pulse_nx = w_pulse_step;
          if (w_pulse_wrap) begin
            w_mil_nx  = w_mil_step;
            w_cost_nx = w_cost_km;
          end
        end else if (tick_1hz) begin
          if (r_idle_s + 8'd1 == c_WAIT_TRIG) begin
            w_state_nx = S_WAIT;
            w_idle_nx  = 8'd0;
            w_sec_nx   = 6'd0;
          end else begin
            w_idle_nx = r_idle_s + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (stop) begin
          w_state_nx = S_HOLD;
        end else if (w_wheel_p) begin
          w_state_nx = S_RUN;
          w_idle_nx  = 8'd0;
          w_sec_nx   = 6'd0;
          w_pulse_nx = w_pulse_step;
          if (w_pulse_wrap) begin
            w_mil_nx  = w_mil_step;
            w_cost_nx = w_cost_km;
          end
        end else if (tick_1hz) begin
          if (r_sec_cnt == c_SEC_LAST) begin
            w_sec_nx = 6'd0;
            if (r_timee != c_TIME_MAX) begin
              w_timee_nx = r_timee + 7'd1;
              w_cost_nx  = w_cost_min;
            end
          end else begin
            w_sec_nx = r_sec_cnt + 6'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_state     <= S_IDLE;
      r_pulse_cnt <= 8'd0;
      r_idle_s    <= 8'd0;
      r_sec_cnt   <= 6'd0;
      r_mil       <= 8'd0;
      r_timee     <= 7'd0;
      r_cost      <= 11'd0;
    end else begin
      r_sync1     <= wheel_in;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_state     <= w_state_nx;
      r_pulse_cnt <= w_pulse_nx;
      r_idle_s    <= w_idle_nx;
      r_sec_cnt   <= w_sec_nx;
      r_mil       <= w_mil_nx;
      r_timee     <= w_timee_nx;
      r_cost      <= w_cost_nx;
    end
  end

  assign mil   = r_mil;
  assign timee = r_timee;
  assign cost  = r_cost;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_taximeter_fare_core.sv
`default_nettype none
// ============================================================================
// tb_taximeter_fare_core : directed and randomized checks of the fare core
// against a trip-level fare model. Revision: 1.0
// ============================================================================
module tb_taximeter_fare_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wheel_in = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        night = 1'b0;
  logic [7:0]  mil;
  logic [6:0]  timee;
  logic [10:0] cost;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_fail = 0;

  // Trip-level model: state code, total pulses, km count, km charge, minutes, seconds.
  int m_state = 0;
  int m_pulses = 0;
  int m_km = 0;
  int m_kmchg = 0;
  int m_min = 0;
  int m_wsec = 0;
  int m_idle = 0;

  taximeter_fare_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .wheel_in (wheel_in),
    .tick_1hz (tick_1hz),
`ifdef NIGHT_RATE_EN
    .night    (night),
`endif
    .mil      (mil),
    .timee    (timee),
    .cost     (cost),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_pulses = 0; m_km = 0; m_kmchg = 0; m_min = 0; m_wsec = 0; m_idle = 0;
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int e_mil, e_t, e_c;
    e_mil = (m_km > 99) ? 99 : m_km;
    e_t   = (m_min > 59) ? 59 : m_min;
    e_c   = (m_state == 0) ? 0 : 10 + m_kmchg + e_t;
    if (e_c > 999) e_c = 999;
    cmp({tag, ".mil"},   int'(mil),   e_mil);
    cmp({tag, ".timee"}, int'(timee), e_t);
    cmp({tag, ".cost"},  int'(cost),  e_c);
    cmp({tag, ".state"}, int'(state), m_state);
  endtask

  task automatic check_const(input string tag, input int e_mil, input int e_t, input int e_c,
                             input int e_st);
    cmp({tag, ".mil"},   int'(mil),   e_mil);
    cmp({tag, ".timee"}, int'(timee), e_t);
    cmp({tag, ".cost"},  int'(cost),  e_c);
    cmp({tag, ".state"}, int'(state), e_st);
  endtask

  task automatic wheel_edge();
    @(negedge clk) wheel_in = 1'b1;
    repeat (4) @(negedge clk);
    wheel_in = 1'b0;
    repeat (3) @(negedge clk);
    if (m_state == 1 || m_state == 2) begin
      m_state = 1;
      m_idle  = 0;
      m_wsec  = 0;
      m_pulses++;
      if (m_pulses % 10 == 0) begin
        m_km++;
        if (m_km >= 4) m_kmchg += night ? 3 : 2;
      end
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) wheel_edge();
  endtask

  task automatic tick();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    if (m_state == 1) begin
      m_idle++;
      if (m_idle == 10) begin
        m_state = 2;
        m_wsec  = 0;
      end
    end else if (m_state == 2) begin
      m_wsec++;
      if (m_wsec == 60) begin
        m_wsec = 0;
        m_min++;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic s_start, input logic s_stop);
    @(negedge clk) begin start = s_start; stop = s_stop; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    if (s_stop) begin
      if (m_state == 1 || m_state == 2) m_state = 3;
    end else if (s_start && (m_state == 0 || m_state == 3)) begin
      model_clear();
      m_state = 1;
    end
  endtask

  initial begin
    int op, n;
    wheel_in = 1'b0;
`ifdef NIGHT_RATE_EN
    night = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_const("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    strobe(1'b0, 1'b1);
    check_const("stop_idle", 0, 0, 0, 0);
    strobe(1'b1, 1'b1);
    check_const("start_stop_idle", 0, 0, 0, 0);

    strobe(1'b1, 1'b0);
    check_const("start", 0, 0, 10, 1);
    edges(50);
    check_const("km50", 5, 0, 14, 1);
    check_model("km50_model");
    strobe(1'b1, 1'b0);
    check_const("start_in_run", 5, 0, 14, 1);

    strobe(1'b0, 1'b1);
    check_const("hold", 5, 0, 14, 3);
    edges(12);
    ticks(15);
    strobe(1'b0, 1'b1);
    check_const("hold_frozen", 5, 0, 14, 3);
    strobe(1'b1, 1'b0);
    check_const("hold_restart", 0, 0, 10, 1);

    edges(30);
    check_const("km3", 3, 0, 10, 1);
    ticks(9);
    check_const("idle9", 3, 0, 10, 1);
    tick();
    check_const("enter_wait", 3, 0, 10, 2);
    ticks(59);
    check_const("wait59s", 3, 0, 10, 2);
    tick();
    check_const("wait1min", 3, 1, 11, 2);
    wheel_edge();
    check_const("wait_to_run", 3, 1, 11, 1);
    check_model("wait_to_run_model");

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 19);
      if (op < 9) begin
        n = $urandom_range(1, 15);
        edges(n);
      end else if (op < 18) begin
        n = $urandom_range(1, 80);
        ticks(n);
      end else if (op == 18) begin
        strobe(1'b0, 1'b1);
      end else begin
        strobe(1'b1, 1'b0);
      end
      check_model("random");
    end

    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    edges(990);
    check_const("mil99", 99, 0, 202, 1);
    edges(3990);
    check_const("cost_sat", 99, 0, 999, 1);
    check_model("cost_sat_model");

    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    ticks(10);
    ticks(3600);
    check_const("timee_sat", 0, 59, 69, 2);
    ticks(60);
    check_const("timee_sat_nocharge", 0, 59, 69, 2);
    strobe(1'b0, 1'b1);
    edges(15);
    ticks(70);
    check_const("wait_stop_frozen", 0, 59, 69, 3);
    strobe(1'b1, 1'b0);
    check_const("restart_after_wait", 0, 0, 10, 1);

`ifdef NIGHT_RATE_EN
    night = 1'b1;
    edges(50);
    check_const("night_km50", 5, 0, 16, 1);
    check_model("night_model");
    night = 1'b0;
`endif

    edges(25);
    check_model("pre_async_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_const("async_reset", 0, 0, 0, 0);
    m_state = 0;
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_model("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
